// File: rtl/ntt_stage_sched.sv
// Address and strobe sequencer for an in-place radix-2 DIF NTT that feeds one
// pipelined butterfly unit from a dual-port coefficient RAM and a twiddle ROM.
module ntt_stage_sched #(
    parameter int LOGN   = 10,
    parameter int BF_LAT = 10,
    parameter int ADDR_W = LOGN,
    localparam int TW_W  = (LOGN > 1) ? LOGN - 1 : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [3:0]        stage,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [TW_W-1:0]   tw_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr0,
    output logic [ADDR_W-1:0] wr_addr1
);

    localparam int WB_LAT = 1 + BF_LAT;
    localparam int CNT_W  = $clog2(WB_LAT + 1);
    localparam int DL_W   = 1 + 2 * ADDR_W;

    localparam logic [TW_W-1:0]  J_LAST     = TW_W'((1 << (LOGN - 1)) - 1);
    localparam logic [3:0]       LAST_STAGE = 4'(LOGN - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(WB_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       stage_nxt;
    logic [TW_W-1:0]  j, j_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [3:0]        shamt;
    logic [ADDR_W-1:0] half, mask, j_ext, k, addr0, tw_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            stage <= '0;
            j     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            stage <= stage_nxt;
            j     <= j_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stage_nxt = stage;
        j_nxt     = j;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    stage_nxt = '0;
                    j_nxt     = '0;
                end
            end
            ISSUE: begin
                j_nxt = j + TW_W'(1);
                if (j == J_LAST) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = CNT_LOAD;
                    j_nxt     = '0;
                end
            end
            DRAIN: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    if (stage == LAST_STAGE) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ISSUE;
                        stage_nxt = stage + 4'd1;
                        j_nxt     = '0;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                stage_nxt = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Butterfly j splits into group g (upper bits) and offset k (low bits below
    // the half-span h); the group bits are shifted up one place to skip the odd half.
    always_comb begin
        shamt   = LAST_STAGE - stage;
        half    = ADDR_W'(1) << shamt;
        mask    = half - ADDR_W'(1);
        j_ext   = ADDR_W'(j);
        k       = j_ext & mask;
        addr0   = ((j_ext & ~mask) << 1) | k;
        tw_full = k << stage;
    end

    assign busy     = (state == ISSUE) || (state == DRAIN);
    assign done     = (state == DONE);
    assign rd_en    = (state == ISSUE);
    assign rd_addr0 = rd_en ? addr0 : '0;
    assign rd_addr1 = rd_en ? addr0 + half : '0;
    assign tw_addr  = rd_en ? TW_W'(tw_full) : '0;

    // Write-back tracks the read issue WB_LAT cycles later; reset flushes it.
    logic [DL_W-1:0] dly [WB_LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WB_LAT; i++) dly[i] <= '0;
        end else begin
            dly[0] <= {rd_en, rd_addr0, rd_addr1};
            for (int i = 1; i < WB_LAT; i++) dly[i] <= dly[i-1];
        end
    end

    assign {wr_en, wr_addr0, wr_addr1} = dly[WB_LAT-1];

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Randomized self-checking bench for ntt_stage_sched; three instances
// (LOGN=3, LOGN=1, LOGN=10) are compared against an arithmetic schedule model.
module tb_ntt_stage_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_v = '0;

    always #5 clk = ~clk;

    logic       busy0, done0, rd_en0, wr_en0;
    logic [3:0] stage0;
    logic [2:0] ra0_0, ra1_0, wa0_0, wa1_0;
    logic [1:0] tw0;

    logic       busy1, done1, rd_en1, wr_en1;
    logic [3:0] stage1;
    logic [0:0] ra0_1, ra1_1, wa0_1, wa1_1;
    logic [0:0] tw1;

    logic       busy2, done2, rd_en2, wr_en2;
    logic [3:0] stage2;
    logic [9:0] ra0_2, ra1_2, wa0_2, wa1_2;
    logic [8:0] tw2;

    ntt_stage_sched #(.LOGN(3), .BF_LAT(4)) dut0 (
        .clk(clk), .reset(rst_n), .start(start_v[0]), .busy(busy0), .done(done0),
        .stage(stage0), .rd_en(rd_en0), .rd_addr0(ra0_0), .rd_addr1(ra1_0),
        .tw_addr(tw0), .wr_en(wr_en0), .wr_addr0(wa0_0), .wr_addr1(wa1_0)
    );

    ntt_stage_sched #(.LOGN(1), .BF_LAT(4)) dut1 (
        .clk(clk), .reset(rst_n), .start(start_v[1]), .busy(busy1), .done(done1),
        .stage(stage1), .rd_en(rd_en1), .rd_addr0(ra0_1), .rd_addr1(ra1_1),
        .tw_addr(tw1), .wr_en(wr_en1), .wr_addr0(wa0_1), .wr_addr1(wa1_1)
    );

    ntt_stage_sched #(.LOGN(10), .BF_LAT(10)) dut2 (
        .clk(clk), .reset(rst_n), .start(start_v[2]), .busy(busy2), .done(done2),
        .stage(stage2), .rd_en(rd_en2), .rd_addr0(ra0_2), .rd_addr1(ra1_2),
        .tw_addr(tw2), .wr_en(wr_en2), .wr_addr0(wa0_2), .wr_addr1(wa1_2)
    );

    int sel = 0;
    int o_busy, o_done, o_stage, o_rd, o_ra0, o_ra1, o_tw, o_wr, o_wa0, o_wa1;

    always_comb begin
        o_busy = 0; o_done = 0; o_stage = 0; o_rd = 0; o_ra0 = 0;
        o_ra1 = 0; o_tw = 0; o_wr = 0; o_wa0 = 0; o_wa1 = 0;
        case (sel)
            0: begin
                o_busy = 32'(busy0); o_done = 32'(done0); o_stage = 32'(stage0);
                o_rd = 32'(rd_en0); o_ra0 = 32'(ra0_0); o_ra1 = 32'(ra1_0); o_tw = 32'(tw0);
                o_wr = 32'(wr_en0); o_wa0 = 32'(wa0_0); o_wa1 = 32'(wa1_0);
            end
            1: begin
                o_busy = 32'(busy1); o_done = 32'(done1); o_stage = 32'(stage1);
                o_rd = 32'(rd_en1); o_ra0 = 32'(ra0_1); o_ra1 = 32'(ra1_1); o_tw = 32'(tw1);
                o_wr = 32'(wr_en1); o_wa0 = 32'(wa0_1); o_wa1 = 32'(wa1_1);
            end
            default: begin
                o_busy = 32'(busy2); o_done = 32'(done2); o_stage = 32'(stage2);
                o_rd = 32'(rd_en2); o_ra0 = 32'(ra0_2); o_ra1 = 32'(ra1_2); o_tw = 32'(tw2);
                o_wr = 32'(wr_en2); o_wa0 = 32'(wa0_2); o_wa1 = 32'(wa1_2);
            end
        endcase
    end

    int test_count = 0;
    int fail_count = 0;
    int cur_cycle = 0;
    int write_cnt [4096];

    task automatic checkOutput(input string tag, input int observed, input int expected);
        test_count++;
        if (observed != expected) begin
            fail_count++;
            $display("[TB] FAIL %s dut=%0d cycle=%0d observed=%0d expected=%0d",
                     tag, sel, cur_cycle, observed, expected);
        end
    endtask

    task automatic checkIdle();
        checkOutput("idle_busy", o_busy, 0);
        checkOutput("idle_done", o_done, 0);
        checkOutput("idle_stage", o_stage, 0);
        checkOutput("idle_rd_en", o_rd, 0);
        checkOutput("idle_wr_en", o_wr, 0);
    endtask

    // Butterfly j of stage s pairs elements g*2h+k and g*2h+k+h, twiddle k*2^s.
    function automatic void bf_pair(input int logn, input int s, input int j,
                                     output int a0, output int a1, output int tw);
        int n, h, k;
        n  = 1 << logn;
        h  = n >> (s + 1);
        k  = j % h;
        a0 = (j / h) * 2 * h + k;
        a1 = a0 + h;
        tw = (k << s) % (n / 2);
    endfunction

    task automatic applyStimulus(input int s_idx, input int extra_start, input int abort_at);
        int logn, wb, n, half_n, p, d, pre;
        int s, r, sw, rw, a0, a1, tw, bad;
        int e_busy, e_rd, e_wr;
        logn   = (s_idx == 0) ? 3 : (s_idx == 1) ? 1 : 10;
        wb     = (s_idx == 2) ? 11 : 5;
        n      = 1 << logn;
        half_n = n / 2;
        p      = half_n + wb;
        d      = 1 + logn * p;
        sel    = s_idx;
        for (int i = 0; i < 4096; i++) write_cnt[i] = 0;

        pre = int'($urandom_range(0, 3));
        for (int i = 0; i < pre; i++) begin
            @(negedge clk);
            cur_cycle = -1;
            checkIdle();
        end
        @(negedge clk);
        cur_cycle = 0;
        checkIdle();
        start_v[s_idx] = 1'b1;

        for (int c = 1; c <= d + 3; c++) begin
            @(negedge clk);
            cur_cycle = c;
            e_busy = (c >= 1 && c < d) ? 1 : 0;
            s = 0;
            r = half_n;
            if (e_busy == 1) begin
                s = (c - 1) / p;
                r = (c - 1) % p;
            end
            e_rd = (e_busy == 1 && r < half_n) ? 1 : 0;
            checkOutput("busy", o_busy, e_busy);
            checkOutput("done", o_done, (c == d) ? 1 : 0);
            if (c != d) checkOutput("stage", o_stage, s);
            checkOutput("rd_en", o_rd, e_rd);
            if (e_rd == 1) begin
                bf_pair(logn, s, r, a0, a1, tw);
                checkOutput("rd_addr0", o_ra0, a0);
                checkOutput("rd_addr1", o_ra1, a1);
                checkOutput("tw_addr", o_tw, tw);
            end

            e_wr = 0;
            sw = 0;
            rw = half_n;
            if (c - wb >= 1 && c - wb < d) begin
                sw = (c - wb - 1) / p;
                rw = (c - wb - 1) % p;
                e_wr = (rw < half_n) ? 1 : 0;
            end
            checkOutput("wr_en", o_wr, e_wr);
            if (o_wr == 1) begin
                write_cnt[o_wa0]++;
                write_cnt[o_wa1]++;
            end
            if (e_wr == 1) begin
                bf_pair(logn, sw, rw, a0, a1, tw);
                checkOutput("wr_addr0", o_wa0, a0);
                checkOutput("wr_addr1", o_wa1, a1);
                if (rw == half_n - 1) begin
                    bad = 0;
                    for (int i = 0; i < n; i++) begin
                        if (write_cnt[i] != 1) bad++;
                        write_cnt[i] = 0;
                    end
                    checkOutput("wr_once", bad, 0);
                end
            end

            start_v[s_idx] = (c == extra_start);
            if (c == abort_at) begin
                start_v[s_idx] = 1'b0;
                rst_n = 1'b0;
                #1;
                checkIdle();
                @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < wb + 3; i++) begin
                    @(negedge clk);
                    cur_cycle = c + 1 + i;
                    checkIdle();
                end
                return;
            end
        end
        start_v[s_idx] = 1'b0;
    endtask

    initial begin
        int s_pick, d_pick, ab;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            checkIdle();
        end
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(0, 12, -1);
        applyStimulus(0, 0, 15);
        applyStimulus(0, int'($urandom_range(1, 28)), -1);
        applyStimulus(1, int'($urandom_range(1, 7)), -1);
        applyStimulus(2, int'($urandom_range(1, 5231)), -1);

        for (int t = 0; t < 4; t++) begin
            s_pick = int'($urandom_range(0, 1));
            d_pick = (s_pick == 0) ? 28 : 7;
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, d_pick - 1)) : -1;
            applyStimulus(s_pick, int'($urandom_range(1, d_pick)), ab);
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/ntt_stage_sched.md
Name: ntt_stage_sched

Overview:
Sequencer for one radix-2 butterfly unit performing an in-place, iterative decimation-in-frequency N-point NTT over a dual-read/dual-write coefficient RAM.
- Per stage, issues one butterfly per cycle: read-address pair plus twiddle ROM address.
- Delays the address pair to match memory and butterfly latency, then issues the write-back.
- Inserts a drain gap between stages so the in-place data is never read before it is written.
- Sits between the top-level control FSM, the coefficient RAM, the twiddle ROM and the butterfly datapath.

Parameters:
- LOGN, 10, log2 of transform size N; legal range 1..12.
- BF_LAT, 10, cycles from butterfly inputs valid to both butterfly outputs valid; the datapath wrapper aligns the even and odd outputs.
- ADDR_W, LOGN, coefficient address width.

Ports:
- clk, in, 1, clock; all logic on the rising edge.
- reset, in, 1, asynchronous, active-low reset; asserting it clears all state immediately.
- start, in, 1, one-cycle pulse requesting a full transform.
- busy, out, 1, high from start acceptance until done.
- done, out, 1, one-cycle pulse when the last write of the last stage has been issued.
- stage, out, 4, current stage index, 0..LOGN-1.
- rd_en, out, 1, read strobe for both RAM ports.
- rd_addr0, out, ADDR_W, even-element read address.
- rd_addr1, out, ADDR_W, odd-element read address.
- tw_addr, out, LOGN-1 (minimum 1), twiddle ROM address; valid with rd_en.
- wr_en, out, 1, write strobe for both RAM ports.
- wr_addr0, out, ADDR_W, write address for the butterfly sum output.
- wr_addr1, out, ADDR_W, write address for the butterfly difference×twiddle output.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters and delay lines cleared.
- Memory and ROM read latency is fixed at 1 cycle.
- Write-back latency WB_LAT = 1 + BF_LAT.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 → ISSUE, with stage=0, butterfly counter j=0, busy=1.
  - start while not in IDLE is ignored.
- ISSUE: one butterfly per cycle, with rd_en=1.
  - h = N >> (stage+1); g = j / h; k = j mod h (shift and mask only, no dividers).
  - rd_addr0 = g·2h + k; rd_addr1 = rd_addr0 + h.
  - tw_addr = k << stage, truncated to the tw_addr width.
  - j increments each cycle. When j = N/2−1: → DRAIN, load drain counter with WB_LAT.
- DRAIN:
  - rd_en=0; drain counter decrements each cycle.
  - When it reaches 1: if stage = LOGN−1 → DONE; else stage+1, j=0, → ISSUE.
  - DRAIN therefore lasts exactly WB_LAT cycles, so the first read of stage s+1 occurs the cycle after the last write of stage s.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then → IDLE.
- Write-back path:
  - {rd_en, rd_addr0, rd_addr1} passes through a WB_LAT-deep shift register and appears as {wr_en, wr_addr0, wr_addr1}.
  - wr_en is never asserted outside a busy period, except the final write, which coincides with the last DRAIN cycle.
- Cycle count per transform:
  - Start accepted at cycle 0; first rd_en at cycle 1.
  - done at cycle 1 + LOGN·(N/2 + WB_LAT).
- Boundary conditions:
  - LOGN=1: single stage, single butterfly (0,1), tw_addr=0.
  - Last stage (h=1): pairs (2j, 2j+1), tw_addr=0.
  - Reset asserted mid-transform: all strobes drop asynchronously; no partial write-back follows after reset release; FSM is in IDLE.
  - start coinciding with the DONE cycle is ignored.
  - stage output holds its value during DRAIN and returns to 0 in IDLE.

Test Plan:
- LOGN=3, BF_LAT=4 (WB_LAT=5), start at cycle 0:
  - Cycles 1–4: rd pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3.
  - Cycles 6–9: wr pairs identical; no rd_en during cycles 5–9.
- Same configuration, stage 1, cycles 10–13: pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2.
  - Stage 2, cycles 19–22: pairs (0,1),(2,3),(4,5),(6,7), tw 0 on all.
  - done=1 only at cycle 28; busy high on cycles 1–27.
- Second start pulse at cycle 12 → ignored; the address sequence and done cycle are unchanged from the first test.
- reset asserted at cycle 15 (during a stage 1 DRAIN) → all outputs 0 the same cycle.
  - After release, no wr_en appears.
  - A new start then replays the stage 0 sequence from cycle 1.
- LOGN=1, BF_LAT=4: rd (0,1) tw 0 at cycle 1; wr (0,1) at cycle 6; done at cycle 7.
- Scoreboard check, LOGN=10: pair each write with its corresponding read 11 cycles earlier.
  - Within a stage, every address 0..1023 is written exactly once.
  - done occurs at cycle 1 + 10·(512+11) = 5231.
